// File: rtl/ddr_rd_stream_if.sv
// Bus bundle for ddr_rd_stream: the DDR read command channel, the returned
// read data, and the forwarded beat stream towards ddr2dbuf.
// master = ddr_rd_stream itself, slave = memory controller / consumer side.
interface ddr_rd_stream_if #(
    parameter int DDR_W      = 512,
    parameter int AXI_ADDR_W = 32,
    parameter int MAX_BURST  = 16
);
    localparam int LEN_W = $clog2(MAX_BURST + 1);

    logic [AXI_ADDR_W-1:0] rd_cmd_addr;
    logic [LEN_W-1:0]      rd_cmd_len;
    logic                  rd_cmd_valid;
    logic                  rd_cmd_ready;
    logic [DDR_W-1:0]      rd_data;
    logic                  rd_data_valid;
    logic [DDR_W-1:0]      ddr_data;
    logic                  ddr_valid;

    modport master (
        output rd_cmd_addr, rd_cmd_len, rd_cmd_valid, ddr_data, ddr_valid,
        input  rd_cmd_ready, rd_data, rd_data_valid
    );

    modport slave (
        input  rd_cmd_addr, rd_cmd_len, rd_cmd_valid, ddr_data, ddr_valid,
        output rd_cmd_ready, rd_data, rd_data_valid
    );
endinterface

// File: rtl/ddr_rd_stream.sv
// ddr_rd_stream: read-side DDR front end for the data-buffer loader.
// On start it walks one contiguous tile with burst read commands, split at
// MAX_BURST and at 4 KB pages, with at most MAX_OUTST beats in flight, and
// forwards returned beats unchanged with one cycle of latency.
// Optional build macro DDR_RD_STAT_EN adds the stat_cycles busy-cycle counter.
module ddr_rd_stream #(
    parameter int DDR_W      = 512,
    parameter int AXI_ADDR_W = 32,
    parameter int MAX_BURST  = 16,
    parameter int MAX_OUTST  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    input  logic [2:0]            mode,
    input  logic [3:0]            ch_num,
    input  logic [3:0]            row_num,
    input  logic [3:0]            pix_num,
    input  logic [AXI_ADDR_W-1:0] base_addr,
    ddr_rd_stream_if.master       bus
`ifdef DDR_RD_STAT_EN
    ,
    output logic [31:0]           stat_cycles
`endif
);

    localparam int LEN_W   = $clog2(MAX_BURST + 1);
    localparam int CNT_W   = 13;
    localparam int BYTE_SH = $clog2(DDR_W / 8);

    typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cmd_rem;
    logic [CNT_W-1:0]      data_rem;
    logic [CNT_W-1:0]      outst;
    logic [CNT_W-1:0]      cmd_beats;
    logic [AXI_ADDR_W-1:0] cur_addr;

    logic [CNT_W-1:0]      ch1, pix1, row1, total;
    logic [CNT_W-1:0]      page_beats, beats;
    logic                  room;
    logic                  beat_in;
    logic                  cmd_acc;
    logic                  mode_unused;

    // Only mode[0] (fc vs conv) matters for the read side.
    assign mode_unused = ^mode[2:1];

    assign beat_in = bus.rd_data_valid && (state != IDLE);
    assign cmd_acc = bus.rd_cmd_valid && bus.rd_cmd_ready;

    // Tile size from config and the size of the next burst at cur_addr.
    always_comb begin
        ch1   = {{(CNT_W-4){1'b0}}, ch_num}  + CNT_W'(1);
        pix1  = {{(CNT_W-4){1'b0}}, pix_num} + CNT_W'(1);
        row1  = {{(CNT_W-4){1'b0}}, row_num} + CNT_W'(1);
        total = mode[0] ? ch1 : CNT_W'(ch1 * pix1 * row1);

        // Beats left before the next 4 KB page; at least 1 for an aligned address.
        page_beats = (CNT_W'(4096) - {1'b0, cur_addr[11:0]}) >> BYTE_SH;
        beats = CNT_W'(MAX_BURST);
        if (cmd_rem < beats)    beats = cmd_rem;
        if (page_beats < beats) beats = page_beats;

        room = ({1'b0, outst} + {1'b0, beats}) <= (CNT_W+1)'(MAX_OUTST);
    end

    // Tile FSM: command issue, outstanding-beat accounting and done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            done             <= 1'b1;
            bus.rd_cmd_valid <= 1'b0;
            bus.rd_cmd_addr  <= '0;
            bus.rd_cmd_len   <= '0;
            bus.ddr_valid    <= 1'b0;
            cmd_rem          <= '0;
            data_rem         <= '0;
            outst            <= '0;
            cmd_beats        <= '0;
            cur_addr         <= '0;
        end else begin
            bus.ddr_valid <= beat_in;
            case (state)
                IDLE: begin
                    if (start) begin
                        cmd_rem  <= total;
                        data_rem <= total;
                        cur_addr <= base_addr;
                        outst    <= '0;
                        done     <= 1'b0;
                        state    <= CMD;
                    end
                end
                CMD, WAIT: begin
                    if (state == CMD) begin
                        if (cmd_acc) begin
                            // A bubble follows every accept so the next burst
                            // is sized from the updated address and remainder.
                            bus.rd_cmd_valid <= 1'b0;
                            cur_addr <= cur_addr + (AXI_ADDR_W'(cmd_beats) << BYTE_SH);
                            cmd_rem  <= cmd_rem - cmd_beats;
                            if (cmd_rem == cmd_beats) state <= WAIT;
                        end else if (!bus.rd_cmd_valid && room) begin
                            bus.rd_cmd_valid <= 1'b1;
                            bus.rd_cmd_addr  <= cur_addr;
                            bus.rd_cmd_len   <= LEN_W'(beats - CNT_W'(1));
                            cmd_beats        <= beats;
                        end
                    end
                    outst <= outst + (cmd_acc ? cmd_beats : '0) - (beat_in ? CNT_W'(1) : '0);
                    if (beat_in) begin
                        data_rem <= data_rem - CNT_W'(1);
                        if (data_rem == CNT_W'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Forwarded beat register, updated only by beats belonging to a tile.
    always_ff @(posedge clk) begin
        if (rst)          bus.ddr_data <= '0;
        else if (beat_in) bus.ddr_data <= bus.rd_data;
    end

`ifdef DDR_RD_STAT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Busy-cycle counter: cleared on accepted start, counts while done is low.
    always_ff @(posedge clk) begin
        if (rst)                        stat_cycles <= '0;
        else if (state == IDLE && start) stat_cycles <= '0;
        else if (!done)                 stat_cycles <= sat_inc(stat_cycles);
    end
`endif

endmodule
